noc_vc_output_arbiter: RTL and testbench
========================================

# noc_vc_output_arbiter

Per-output-port scheduler for a NoC router. It shares one output link between the `virtual_channels` VCs of that port, using round-robin selection with per-VC credit-based flow control against the downstream input FIFOs. It locks the link to one VC from head flit to tail flit, so packets never interleave on the link. It sits between the router's VC output buffers and the link mux, and drives the mux select.

## Interface
Parameters:
- `NOC_CONFIG`, default `NOC_DEFAULT_CONFIG`: `noc_config` struct. Uses `.virtual_channels` (VCS) and `.input_fifo_depth` (DEPTH).
- `VCS`, default `NOC_CONFIG.virtual_channels`: number of VCs. Derived; do not override.
- `CREDIT_W`, default `$clog2(DEPTH+1)`: credit counter width.
- `SEL_W`, default `(VCS > 1) ? $clog2(VCS) : 1`: select width.

Ports (clock is single; reset is asynchronous, active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `i_request` in VCS: VC v has a valid head-of-queue flit.
- `i_last` in VCS: that flit is the packet's tail; single-flit packets assert it on the head.
- `i_credit_return` in VCS: downstream freed one FIFO entry of VC v.
- `o_grant` in/out: out VCS, one-hot or zero. The flit of VC v is transferred this cycle.
- `o_valid` out 1: `|o_grant`.
- `o_vc_select` out SEL_W: index of the granted VC; holds its last value when `o_valid`=0.
- `o_credit_available` out VCS: VC v credit count is greater than 0.
- `o_credit_error` out 1: sticky flag, set on a credit return while the count is DEPTH.

## Operation
- **Credit counters:** one per VC, reset to DEPTH.
  - Next value = count − grant[v] + credit_return[v].
  - Grant and return in the same cycle leave the count unchanged.
  - A return at DEPTH keeps the count at DEPTH and sets `o_credit_error`.
  - A grant at 0 cannot occur.
- **Eligibility:** `elig[v] = i_request[v] && count[v] != 0`. It uses the registered count; a same-cycle return does not count.
- **FSM, state IDLE:**
  - Round-robin pick among `elig`, starting at pointer `rr_ptr` and wrapping modulo VCS.
  - If the picked flit has `i_last`=0: go to LOCKED, `lock_vc` ← picked.
  - If `i_last`=1: stay in IDLE, `rr_ptr` ← (picked+1) mod VCS.
  - If nothing is eligible: no grant, pointer unchanged.
- **FSM, state LOCKED:**
  - Grant only `lock_vc`, and only when `elig[lock_vc]`. Otherwise no grant (the link stalls and other VCs wait).
  - When a granted flit has `i_last`=1: go to IDLE, `rr_ptr` ← (lock_vc+1) mod VCS.
- **VCS = 1:** degenerates to credit gating only; the pointer stays 0.
- **Assertions:** `o_grant` is one-hot or zero; `o_grant[v]` implies `elig[v]`.

## Timing
- **Reset values (async on `rst`):**
  - state=IDLE, `rr_ptr`=0, `lock_vc`=0, counts=DEPTH, `o_credit_error`=0.
  - Hence `o_grant`=0, `o_valid`=0, `o_vc_select`=0, `o_credit_available`=all ones.
- **Latency:** `o_grant`, `o_valid` and `o_vc_select` are combinational from `i_request`/`i_last` and registered state. Zero-cycle request-to-grant.
- **Update timing:** state, pointer, lock and counts update on the `clk` edge after a grant; new credits become usable the cycle after a return.
- **Sustained rate:** a single VC with DEPTH credits and no returns gets exactly DEPTH consecutive grants, then stalls.
- **Reset mid-packet:** the lock is dropped and credits are restored to DEPTH. Upstream and downstream are reset together.

## Structure
- `noc_config_pkg` gains `typedef enum logic {NOC_ARB_IDLE, NOC_ARB_LOCKED}` for the FSM states.
- A `noc_config_pkg` helper function derives `CREDIT_W` from a `noc_config`.
- Sub-module `noc_round_robin_arbiter`: combinational, with inputs request vector and pointer, and a one-hot grant output. Reusable by the router's input-side switch allocator.
- Credit counters live in a generate loop in the top module.

## Test plan
- **Reset values:** reset, then sample → `o_valid`=0, `o_credit_available`=all ones, `o_credit_error`=0.
- **Round-robin:** VCS=2, DEPTH=8; both VCs request single-flit packets every cycle with returns each cycle → grants alternate VC0, VC1, VC0, …
- **Packet lock:** VC0 sends a 4-flit packet and VC1 requests throughout → VC0 is granted 4 consecutive cycles, then VC1. A VC0 request bubble in flit 2 gives a cycle with no grant (VC1 is not granted).
- **Credit exhaustion:** VC0 only, no returns → 8 grants, then `o_credit_available[0]`=0 and no grant. One return → grant resumes exactly one cycle later.
- **Simultaneous grant and return:** at count 3 → count stays 3.
- **Credit error:** return at count 8 → `o_credit_error`=1 and stays 1 until `rst`.

Source files
------------

// File: rtl/noc_config_pkg.sv
// -----------------------------------------------------------------------------
// noc_config_pkg
// Shared NoC configuration types for router blocks.
//   noc_config          : structural parameters of a router port
//   NOC_DEFAULT_CONFIG  : 2 virtual channels, 8-entry downstream input FIFOs
//   noc_arb_state_e     : output-arbiter packet FSM states
//   noc_credit_width()  : counter width able to hold 0..input_fifo_depth
// -----------------------------------------------------------------------------
package noc_config_pkg;

    typedef struct packed {
        int virtual_channels;
        int input_fifo_depth;
    } noc_config;

    localparam noc_config NOC_DEFAULT_CONFIG = '{
        virtual_channels: 2,
        input_fifo_depth: 8
    };

    typedef enum logic {
        NOC_ARB_IDLE,
        NOC_ARB_LOCKED
    } noc_arb_state_e;

    function automatic int noc_credit_width(input noc_config cfg);
        return $clog2(cfg.input_fifo_depth + 1);
    endfunction

endpackage

// File: rtl/noc_round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// noc_round_robin_arbiter
// Combinational round-robin picker. Scans the request vector starting at
// index ptr and wrapping modulo N; the first set request wins.
//   req   in  N      : request vector
//   ptr   in  PTR_W  : highest-priority index (expected < N)
//   grant out N      : one-hot winner, zero when no request is set
// -----------------------------------------------------------------------------
module noc_round_robin_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_vc_output_arbiter.sv
// -----------------------------------------------------------------------------
// noc_vc_output_arbiter
// Per-output-port scheduler: shares one link among VCS virtual channels with
// round-robin selection, per-VC credit flow control, and packet locking from
// head flit to tail flit.
//
// Handshake: a flit of VC v moves across the link in exactly the cycle where
// i_request[v] (valid) and o_grant[v] (ready) are both high; i_request may
// be held across cycles without a grant and nothing is transferred then.
//
//   clk, rst             : clock, asynchronous active-high reset
//   i_request[v]         : VC v has a head-of-queue flit
//   i_last[v]            : that flit is the packet tail
//   i_credit_return[v]   : downstream freed one FIFO entry of VC v
//   o_grant[v]           : flit of VC v is transferred this cycle (one-hot/0)
//   o_valid              : any grant this cycle
//   o_vc_select          : granted VC index, holds last value when idle
//   o_credit_available[v]: VC v credit count is non-zero
//   o_credit_error       : sticky, a credit came back while count was full
//   o_state              : debug view of the FSM (1 = locked on a packet)
// -----------------------------------------------------------------------------
module noc_vc_output_arbiter
    import noc_config_pkg::*;
#(
    parameter noc_config NOC_CONFIG = NOC_DEFAULT_CONFIG,
    parameter int VCS      = NOC_CONFIG.virtual_channels,
    parameter int CREDIT_W = noc_credit_width(NOC_CONFIG),
    parameter int SEL_W    = (VCS > 1) ? $clog2(VCS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VCS-1:0]   i_request,
    input  logic [VCS-1:0]   i_last,
    input  logic [VCS-1:0]   i_credit_return,
    output logic [VCS-1:0]   o_grant,
    output logic             o_valid,
    output logic [SEL_W-1:0] o_vc_select,
    output logic [VCS-1:0]   o_credit_available,
    output logic             o_credit_error,
    output logic             o_state
);

    localparam int                  DEPTH = NOC_CONFIG.input_fifo_depth;
    localparam logic [CREDIT_W-1:0] FULL  = CREDIT_W'(DEPTH);

    noc_arb_state_e   state_q, state_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] lock_vc_q, lock_vc_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] pick_idx, grant_idx;
    logic [VCS-1:0]   elig, rr_grant, grant, err_set;
    logic             err_q;

    // Index after idx, wrapping at VCS; with a single VC it is always 0.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
        if (int'(idx) >= VCS - 1) return '0;
        return idx + 1'b1;
    endfunction

    // Credit counters. Eligibility uses the registered count, so a credit
    // returned this cycle is only usable from the next cycle on.
    for (genvar v = 0; v < VCS; v++) begin : g_credit
        logic [CREDIT_W-1:0] count_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                count_q <= FULL;
            end else begin
                case ({grant[v], i_credit_return[v]})
                    2'b10:   count_q <= count_q - 1'b1;
                    // Overflowing return is clamped; err_set flags it.
                    2'b01:   if (count_q != FULL) count_q <= count_q + 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end

        assign elig[v]               = i_request[v] && (count_q != '0);
        assign o_credit_available[v] = (count_q != '0);
        assign err_set[v]            = i_credit_return[v] && (count_q == FULL);
    end

    noc_round_robin_arbiter #(
        .N     (VCS),
        .PTR_W (SEL_W)
    ) u_rr (
        .req   (elig),
        .ptr   (rr_ptr_q),
        .grant (rr_grant)
    );

    always_comb begin
        pick_idx = '0;
        for (int v = 0; v < VCS; v++) begin
            if (rr_grant[v]) pick_idx = SEL_W'(v);
        end
    end

    // Packet FSM: IDLE arbitrates per flit; LOCKED serves only lock_vc until
    // its tail, stalling the link if that VC has no flit or no credit.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_vc_d = lock_vc_q;
        grant     = '0;
        case (state_q)
            NOC_ARB_IDLE: begin
                if (|rr_grant) begin
                    grant = rr_grant;
                    if (i_last[pick_idx]) begin
                        rr_ptr_d = wrap_inc(pick_idx);
                    end else begin
                        state_d   = NOC_ARB_LOCKED;
                        lock_vc_d = pick_idx;
                    end
                end
            end
            NOC_ARB_LOCKED: begin
                if (elig[lock_vc_q]) begin
                    grant[lock_vc_q] = 1'b1;
                    if (i_last[lock_vc_q]) begin
                        state_d  = NOC_ARB_IDLE;
                        rr_ptr_d = wrap_inc(lock_vc_q);
                    end
                end
            end
            default: state_d = NOC_ARB_IDLE;
        endcase
    end

    always_comb begin
        grant_idx = '0;
        for (int v = 0; v < VCS; v++) begin
            if (grant[v]) grant_idx = SEL_W'(v);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= NOC_ARB_IDLE;
            rr_ptr_q  <= '0;
            lock_vc_q <= '0;
            sel_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_vc_q <= lock_vc_d;
            if (|grant) sel_q <= grant_idx;
            if (|err_set) err_q <= 1'b1;
        end
    end

    assign o_grant        = grant;
    assign o_valid        = |grant;
    assign o_vc_select    = (|grant) ? grant_idx : sel_q;
    assign o_credit_error = err_q;
    assign o_state        = (state_q == NOC_ARB_LOCKED);

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(grant));
            assert ((grant & ~elig) == '0);
        end
    end

endmodule

// File: tb/tb_noc_vc_output_arbiter.sv
module tb_noc_vc_output_arbiter;
    import noc_config_pkg::*;

    localparam int VCS   = 2;
    localparam int DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] i_request       = '0;
    logic [1:0] i_last          = '0;
    logic [1:0] i_credit_return = '0;
    logic [1:0] o_grant;
    logic       o_valid;
    logic [0:0] o_vc_select;
    logic [1:0] o_credit_available;
    logic       o_credit_error;
    logic       o_state;

    always #5 clk = ~clk;

    noc_vc_output_arbiter dut (
        .clk                (clk),
        .rst                (rst),
        .i_request          (i_request),
        .i_last             (i_last),
        .i_credit_return    (i_credit_return),
        .o_grant            (o_grant),
        .o_valid            (o_valid),
        .o_vc_select        (o_vc_select),
        .o_credit_available (o_credit_available),
        .o_credit_error     (o_credit_error),
        .o_state            (o_state)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Packet-level view: credits per VC, whether a packet is open and on
    // which VC, who has first priority next, and the last VC that was sent.
    int m_cred[VCS];
    int m_ptr;
    int m_lock;
    int m_sel;
    bit m_locked;
    bit m_err;
    logic [1:0] last_grant;

    task automatic model_reset();
        for (int v = 0; v < VCS; v++) m_cred[v] = DEPTH;
        m_ptr    = 0;
        m_lock   = 0;
        m_sel    = 0;
        m_locked = 0;
        m_err    = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst             = 1'b1;
        i_request       = '0;
        i_last          = '0;
        i_credit_return = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_cycle(input logic [1:0] req, input logic [1:0] last,
                            input logic [1:0] ret, input string tag);
        int         g;
        int         nc;
        logic [1:0] exp_grant;
        logic [1:0] exp_avail;
        i_request       = req;
        i_last          = last;
        i_credit_return = ret;
        @(negedge clk);
        g = -1;
        if (m_locked) begin
            if (req[m_lock] && m_cred[m_lock] > 0) g = m_lock;
        end else begin
            for (int k = 0; k < VCS; k++) begin
                int v;
                v = (m_ptr + k) % VCS;
                if (g < 0 && req[v] && m_cred[v] > 0) g = v;
            end
        end
        exp_grant = '0;
        if (g >= 0) exp_grant[g] = 1'b1;
        for (int v = 0; v < VCS; v++) exp_avail[v] = (m_cred[v] > 0);
        check({tag, "_grant"}, 32'(o_grant), 32'(exp_grant));
        check({tag, "_valid"}, 32'(o_valid), 32'(g >= 0));
        check({tag, "_sel"},   32'(o_vc_select), (g >= 0) ? 32'(g) : 32'(m_sel));
        check({tag, "_avail"}, 32'(o_credit_available), 32'(exp_avail));
        check({tag, "_err"},   32'(o_credit_error), 32'(m_err));
        check({tag, "_state"}, 32'(o_state), 32'(m_locked));
        last_grant = o_grant;
        // advance the model to the post-edge view
        for (int v = 0; v < VCS; v++) begin
            if (ret[v] && m_cred[v] == DEPTH) m_err = 1;
            nc = m_cred[v] - ((g == v) ? 1 : 0) + (ret[v] ? 1 : 0);
            m_cred[v] = (nc > DEPTH) ? DEPTH : nc;
        end
        if (g >= 0) begin
            m_sel = g;
            if (last[g]) begin
                m_locked = 0;
                m_ptr    = (g + 1) % VCS;
            end else begin
                m_locked = 1;
                m_lock   = g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        logic [1:0] r_req, r_last, r_ret;

        // reset values
        do_reset();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_sel",   32'(o_vc_select), 32'd0);
        check("rst_avail", 32'(o_credit_available), 32'h3);
        check("rst_err",   32'(o_credit_error), 32'd0);

        // round robin on single-flit packets
        for (int i = 0; i < 6; i++) begin
            do_cycle(2'b11, 2'b11, 2'b00, "rr");
            check("rr_alternate", 32'(last_grant), (i % 2 == 0) ? 32'h1 : 32'h2);
        end

        // packet lock with a bubble on the locked VC
        do_reset();
        do_cycle(2'b11, 2'b10, 2'b00, "lock_head");
        check("lock_head_vc0", 32'(last_grant), 32'h1);
        do_cycle(2'b11, 2'b10, 2'b00, "lock_f2");
        check("lock_f2_vc0", 32'(last_grant), 32'h1);
        do_cycle(2'b10, 2'b10, 2'b00, "lock_bubble");
        check("lock_bubble_none", 32'(last_grant), 32'h0);
        do_cycle(2'b11, 2'b10, 2'b00, "lock_f3");
        check("lock_f3_vc0", 32'(last_grant), 32'h1);
        do_cycle(2'b11, 2'b11, 2'b00, "lock_tail");
        check("lock_tail_vc0", 32'(last_grant), 32'h1);
        do_cycle(2'b10, 2'b10, 2'b00, "lock_next");
        check("lock_next_vc1", 32'(last_grant), 32'h2);

        // credit exhaustion and resume one cycle after a return
        do_reset();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            do_cycle(2'b01, 2'b01, 2'b00, "exh");
            if (last_grant[0]) n++;
        end
        check("exh_grants", 32'(n), 32'(DEPTH));
        check("exh_avail0", 32'(o_credit_available[0]), 32'd0);
        do_cycle(2'b01, 2'b01, 2'b01, "exh_ret");
        check("exh_ret_same_cycle", 32'(last_grant), 32'h0);
        do_cycle(2'b01, 2'b01, 2'b00, "exh_resume");
        check("exh_resume_grant", 32'(last_grant), 32'h1);

        // simultaneous grant and return at count 3
        do_reset();
        for (int i = 0; i < DEPTH - 3; i++) do_cycle(2'b01, 2'b01, 2'b00, "sim_pre");
        do_cycle(2'b01, 2'b01, 2'b01, "sim_both");
        n = 0;
        for (int i = 0; i < 5; i++) begin
            do_cycle(2'b01, 2'b01, 2'b00, "sim_post");
            if (last_grant[0]) n++;
        end
        check("sim_count_kept", 32'(n), 32'd3);

        // credit error is sticky until reset
        do_reset();
        do_cycle(2'b00, 2'b00, 2'b01, "err_set");
        for (int i = 0; i < 3; i++) do_cycle(2'b10, 2'b10, 2'b00, "err_hold");
        check("err_sticky", 32'(o_credit_error), 32'd1);
        do_reset();
        check("err_cleared", 32'(o_credit_error), 32'd0);

        // reset in the middle of a packet drops the lock
        do_cycle(2'b10, 2'b00, 2'b00, "mid_head");
        check("mid_locked", 32'(o_state), 32'd1);
        do_reset();
        do_cycle(2'b11, 2'b11, 2'b00, "mid_after");
        check("mid_after_vc0", 32'(last_grant), 32'h1);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r_req  = 2'($urandom_range(0, 3));
            r_last = '0;
            r_ret  = '0;
            for (int v = 0; v < VCS; v++) begin
                r_last[v] = ($urandom_range(0, 2) == 0);
                r_ret[v]  = (m_cred[v] < DEPTH) && ($urandom_range(0, 1) == 1);
            end
            do_cycle(r_req, r_last, r_ret, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
